// File: rtl/ans_pkg.sv
// Shared widths and enums for the ANS frequency table: the FSM states and the
// query types (lookup by symbol for the encoder, lookup by slot for the decoder).
package ans_pkg;

  localparam int SYM_WIDTH = 4;
  localparam int CNT_WIDTH = 4;
  localparam int CUM_WIDTH = 8;
  localparam int SYM_COUNT = 1 << SYM_WIDTH;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_READY,
    ST_SEARCH,
    ST_RESP
  } state_e;

  typedef enum logic {
    Q_SYM  = 1'b0,
    Q_SLOT = 1'b1
  } qtype_e;

endpackage

// File: rtl/ans_freq_mem.sv
// Per-symbol {count, cumulative} register file: one write port and one
// combinational read port. Contents are unreset; the table is always reloaded.
module ans_freq_mem #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 4,
  parameter int CUM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [SYM_WIDTH-1:0] waddr,
  input  logic [CNT_WIDTH-1:0] wcnt,
  input  logic [CUM_WIDTH-1:0] wcum,
  input  logic [SYM_WIDTH-1:0] raddr,
  output logic [CNT_WIDTH-1:0] rcnt,
  output logic [CUM_WIDTH-1:0] rcum
);

  localparam int NSYM = 1 << SYM_WIDTH;

  logic [CNT_WIDTH-1:0] cnt_q [NSYM];
  logic [CUM_WIDTH-1:0] cum_q [NSYM];

  always_ff @(posedge clk) begin
    if (we) begin
      cnt_q[waddr] <= wcnt;
      cum_q[waddr] <= wcum;
    end
  end

  assign rcnt = cnt_q[raddr];
  assign rcum = cum_q[raddr];

endmodule

// File: rtl/ans_freq_table.sv
// ANS frequency table: loads one count per symbol, then answers symbol lookups
// in one cycle and slot lookups by a linear scan, one index per cycle.
module ans_freq_table #(
  parameter int SYM_WIDTH = ans_pkg::SYM_WIDTH,
  parameter int CNT_WIDTH = ans_pkg::CNT_WIDTH,
  parameter int CUM_WIDTH = ans_pkg::CUM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] load_cnt,
  input  logic                 load_vld,
  output logic                 load_rdy,
  output logic                 tbl_vld,
  output logic [CUM_WIDTH-1:0] total,
  input  logic                 q_type,
  input  logic [CUM_WIDTH-1:0] q_key,
  input  logic                 q_vld,
  output logic                 q_rdy,
  output logic [SYM_WIDTH-1:0] r_sym,
  output logic [CNT_WIDTH-1:0] r_cnt,
  output logic [CUM_WIDTH-1:0] r_cum,
  output logic                 r_err,
  output logic                 r_vld,
  input  logic                 r_rdy
);

  import ans_pkg::*;

  localparam int IDX_W = SYM_WIDTH + 1;
  localparam int CW1   = CUM_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_SYM = IDX_W'((1 << SYM_WIDTH) - 1);
  localparam logic [IDX_W-1:0] SCAN_END = IDX_W'(1 << SYM_WIDTH);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CUM_WIDTH-1:0] sum_q, sum_d;
  logic [CUM_WIDTH-1:0] total_q, total_d;
  logic [CUM_WIDTH-1:0] key_q, key_d;
  logic [SYM_WIDTH-1:0] r_sym_q, r_sym_d;
  logic [CNT_WIDTH-1:0] r_cnt_q, r_cnt_d;
  logic [CUM_WIDTH-1:0] r_cum_q, r_cum_d;
  logic                 r_err_q, r_err_d;

  logic                 mem_we;
  logic [SYM_WIDTH-1:0] mem_raddr;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [CUM_WIDTH-1:0] rd_cum;

  logic [CW1-1:0]       slot_ext, lo_ext, hi_ext;
  logic                 slot_hit;

  ans_freq_mem #(
    .SYM_WIDTH(SYM_WIDTH),
    .CNT_WIDTH(CNT_WIDTH),
    .CUM_WIDTH(CUM_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(idx_q[SYM_WIDTH-1:0]),
    .wcnt (load_cnt),
    .wcum (sum_q),
    .raddr(mem_raddr),
    .rcnt (rd_cnt),
    .rcum (rd_cum)
  );

  // One bit wider so cum+cnt of the last populated symbol cannot wrap.
  assign slot_ext = {1'b0, key_q};
  assign lo_ext   = {1'b0, rd_cum};
  assign hi_ext   = lo_ext + CW1'(rd_cnt);
  assign slot_hit = (rd_cnt != '0) && (slot_ext >= lo_ext) && (slot_ext < hi_ext);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    total_d   = total_q;
    key_d     = key_q;
    r_sym_d   = r_sym_q;
    r_cnt_d   = r_cnt_q;
    r_cum_d   = r_cum_q;
    r_err_d   = r_err_q;
    mem_we    = 1'b0;
    mem_raddr = idx_q[SYM_WIDTH-1:0];

    case (state_q)
      ST_LOAD: begin
        if (load_vld) begin
          mem_we = 1'b1;
          sum_d  = sum_q + CUM_WIDTH'(load_cnt);
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == LAST_SYM) begin
            state_d = ST_READY;
            total_d = sum_d;
            idx_d   = '0;
          end
        end
      end
      ST_READY: begin
        mem_raddr = q_key[SYM_WIDTH-1:0];
        if (q_vld) begin
          key_d = q_key;
          if (qtype_e'(q_type) == Q_SYM) begin
            state_d = ST_RESP;
            r_sym_d = q_key[SYM_WIDTH-1:0];
            r_cnt_d = rd_cnt;
            r_cum_d = rd_cum;
            r_err_d = 1'b0;
          end else begin
            state_d = ST_SEARCH;
            idx_d   = '0;
          end
        end
      end
      ST_SEARCH: begin
        // Index SCAN_END means every symbol was tested without a hit.
        if (idx_q == SCAN_END) begin
          state_d = ST_RESP;
          r_sym_d = '0;
          r_cnt_d = '0;
          r_cum_d = '0;
          r_err_d = 1'b1;
        end else if (slot_hit) begin
          state_d = ST_RESP;
          r_sym_d = idx_q[SYM_WIDTH-1:0];
          r_cnt_d = rd_cnt;
          r_cum_d = rd_cum;
          r_err_d = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_RESP: begin
        if (r_rdy) state_d = ST_READY;
      end
      default: state_d = ST_LOAD;
    endcase

    if (clear) begin
      state_d = ST_LOAD;
      idx_d   = '0;
      sum_d   = '0;
      total_d = '0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      sum_q   <= '0;
      total_q <= '0;
      r_sym_q <= '0;
      r_cnt_q <= '0;
      r_cum_q <= '0;
      r_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      total_q <= total_d;
      r_sym_q <= r_sym_d;
      r_cnt_q <= r_cnt_d;
      r_cum_q <= r_cum_d;
      r_err_q <= r_err_d;
    end
  end

  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  assign load_rdy = (state_q == ST_LOAD);
  assign tbl_vld  = (state_q != ST_LOAD);
  assign q_rdy    = (state_q == ST_READY);
  assign r_vld    = (state_q == ST_RESP);
  assign total    = total_q;
  assign r_sym    = r_sym_q;
  assign r_cnt    = r_cnt_q;
  assign r_cum    = r_cum_q;
  assign r_err    = r_err_q;

endmodule

// File: tb/tb_ans_freq_table.sv
// Bench for ans_freq_table: directed table/query cases plus randomized tables
// and queries checked against an array-based model of the frequency table.
module tb_ans_freq_table;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] load_cnt = '0;
  logic       load_vld = 1'b0;
  logic       load_rdy;
  logic       tbl_vld;
  logic [7:0] total;
  logic       q_type = 1'b0;
  logic [7:0] q_key = '0;
  logic       q_vld = 1'b0;
  logic       q_rdy;
  logic [3:0] r_sym;
  logic [3:0] r_cnt;
  logic [7:0] r_cum;
  logic       r_err;
  logic       r_vld;
  logic       r_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  int tab[16];
  int m_cnt[16];
  int m_cum[16];
  int m_total;

  ans_freq_table dut (
    .clk(clk), .rst(rst), .clear(clear),
    .load_cnt(load_cnt), .load_vld(load_vld), .load_rdy(load_rdy),
    .tbl_vld(tbl_vld), .total(total),
    .q_type(q_type), .q_key(q_key), .q_vld(q_vld), .q_rdy(q_rdy),
    .r_sym(r_sym), .r_cnt(r_cnt), .r_cum(r_cum), .r_err(r_err),
    .r_vld(r_vld), .r_rdy(r_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_load(input string tag);
    chk({tag, " r_vld"}, r_vld, 0);
    chk({tag, " tbl_vld"}, tbl_vld, 0);
    chk({tag, " load_rdy"}, load_rdy, 1);
    chk({tag, " q_rdy"}, q_rdy, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_idle_load("clear");
  endtask

  // Loads tab[] with occasional idle cycles; the model is the running prefix sum.
  task automatic load_table();
    int sum = 0;
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = tab[i];
      m_cum[i] = sum;
      sum += tab[i];
    end
    m_total = sum;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(3) == 0) begin
        load_vld = 1'b0;
        step();
      end
      if (i == 0) chk("load_rdy first", load_rdy, 1);
      if (i == 15) chk("tbl_vld before last", tbl_vld, 0);
      load_vld = 1'b1;
      load_cnt = 4'(tab[i]);
      step();
    end
    load_vld = 1'b0;
    chk("tbl_vld loaded", tbl_vld, 1);
    chk("total", total, m_total);
    chk("load_rdy after load", load_rdy, 0);
    chk("q_rdy after load", q_rdy, 1);
  endtask

  task automatic query(input bit typ, input int key, input int hold);
    int es, ec, eu, ee, el, lat;
    if (!typ) begin
      es = key % 16; ec = m_cnt[es]; eu = m_cum[es]; ee = 0; el = 1;
    end else begin
      es = 0; ec = 0; eu = 0; ee = 1; el = 18;
      for (int i = 0; i < 16; i++) begin
        if (ee == 1 && m_cnt[i] != 0 && key >= m_cum[i] && key < m_cum[i] + m_cnt[i]) begin
          es = i; ec = m_cnt[i]; eu = m_cum[i]; ee = 0; el = i + 2;
        end
      end
    end
    chk("q_rdy before query", q_rdy, 1);
    q_type = typ;
    q_key  = 8'(key);
    q_vld  = 1'b1;
    step();
    q_vld = 1'b0;
    lat = 1;
    while (!r_vld && lat < 40) begin
      step();
      lat++;
    end
    chk("latency", lat, el);
    chk("r_vld", r_vld, 1);
    chk("r_sym", r_sym, es);
    chk("r_cnt", r_cnt, ec);
    chk("r_cum", r_cum, eu);
    chk("r_err", r_err, ee);
    for (int h = 0; h < hold; h++) begin
      // Stray handshakes while the response waits must change nothing.
      q_vld = 1'b1; q_key = 8'($urandom_range(255));
      load_vld = 1'b1; load_cnt = 4'hf;
      step();
      chk("hold r_vld", r_vld, 1);
      chk("hold q_rdy", q_rdy, 0);
      chk("hold r_sym", r_sym, es);
      chk("hold r_cnt", r_cnt, ec);
      chk("hold r_cum", r_cum, eu);
      chk("hold r_err", r_err, ee);
    end
    q_vld = 1'b0;
    load_vld = 1'b0;
    r_rdy = 1'b1;
    step();
    r_rdy = 1'b0;
    chk("r_vld after xfer", r_vld, 0);
    chk("q_rdy after xfer", q_rdy, 1);
    chk("total stable", total, m_total);
  endtask

  task automatic directed_table();
    for (int i = 0; i < 15; i++) tab[i] = i + 1;
    tab[15] = 0;
  endtask

  task automatic random_table();
    for (int i = 0; i < 16; i++)
      tab[i] = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15));
  endtask

  initial begin
    step();
    step();
    chk("rst load_rdy", load_rdy, 1);
    chk("rst tbl_vld", tbl_vld, 0);
    chk("rst q_rdy", q_rdy, 0);
    chk("rst r_vld", r_vld, 0);
    chk("rst total", total, 0);
    chk("rst r_sym", r_sym, 0);
    chk("rst r_cnt", r_cnt, 0);
    chk("rst r_cum", r_cum, 0);
    chk("rst r_err", r_err, 0);
    rst = 1'b0;

    directed_table();
    load_table();
    chk("directed total", total, 120);
    query(1'b0, 5, 0);
    query(1'b0, 8'hf3, 0);
    query(1'b1, 16, 0);
    query(1'b1, 0, 0);
    query(1'b1, 119, 0);
    query(1'b1, 120, 0);
    query(1'b1, 255, 0);
    query(1'b0, 3, 5);

    do_clear();
    for (int i = 0; i < 16; i++) tab[i] = 0;
    load_table();
    query(1'b1, 0, 0);
    query(1'b0, 7, 0);

    // Clear while a slot scan is in flight.
    do_clear();
    directed_table();
    load_table();
    q_type = 1'b1; q_key = 8'd120; q_vld = 1'b1;
    step();
    q_vld = 1'b0;
    step(); step(); step();
    do_clear();
    step(); step();
    chk("no stale r_vld", r_vld, 0);
    random_table();
    load_table();
    query(1'b1, $urandom_range(255), 1);

    // Reset partway through a load, with clear also high.
    do_clear();
    for (int i = 0; i < 8; i++) begin
      load_vld = 1'b1; load_cnt = 4'(i + 3);
      step();
    end
    chk("mid-load tbl_vld", tbl_vld, 0);
    rst = 1'b1; clear = 1'b1;
    step();
    rst = 1'b0; clear = 1'b0; load_vld = 1'b0;
    chk_idle_load("rst");
    chk("rst total after load", total, 0);
    directed_table();
    load_table();
    query(1'b1, 16, 0);

    for (int t = 0; t < 4; t++) begin
      do_clear();
      random_table();
      load_table();
      for (int q = 0; q < 12; q++) begin
        bit typ;
        int key;
        typ = 1'($urandom_range(1));
        if (typ && m_total > 0 && $urandom_range(3) != 0) key = $urandom_range(m_total - 1);
        else key = $urandom_range(255);
        query(typ, key, $urandom_range(2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
